// File: rtl/sram_pack_pkg.sv
// Shared constants for the SRAM pack controller: burst size, skid depth and ring capacity.
package sram_pack_pkg;
  localparam int BURST  = 4;
  localparam int SKID_N = 2;

  // The top 4-word slot is kept unused so the read address (rd_ptr+1) stays in range.
  function automatic int cap(input int depth);
    return depth - BURST;
  endfunction
endpackage

// File: rtl/sram_rd_skid.sv
// Two-entry fall-through output buffer for SRAM read data; empty buffer passes data straight through.
module sram_rd_skid #(
  parameter int WIDTH = 10
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic [1:0]       o_occ
);
  logic [1:0]       r_occ;
  logic [WIDTH-1:0] r_d0;
  logic [WIDTH-1:0] r_d1;
  logic             w_pop;
  logic             w_pop_q;
  logic             w_push_q;
  logic [1:0]       w_slot;
  logic [1:0]       w_occ_nxt;

  always_comb begin
    o_valid   = ~i_flush & ((r_occ != 2'd0) | i_valid);
    o_data    = '0;
    if (o_valid) o_data = (r_occ != 2'd0) ? r_d0 : i_data;
    o_occ     = r_occ;
    w_pop     = o_valid & i_ready;
    // A word handed out while the buffer is empty bypasses storage entirely.
    w_pop_q   = w_pop & (r_occ != 2'd0);
    w_push_q  = i_valid & ~i_flush & ~(w_pop & (r_occ == 2'd0));
    w_slot    = r_occ - 2'(w_pop_q);
    w_occ_nxt = r_occ + 2'(w_push_q) - 2'(w_pop_q);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)     r_occ <= 2'd0;
    else if (i_flush) r_occ <= 2'd0;
    else              r_occ <= w_occ_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (w_pop_q) r_d0 <= r_d1;
    if (w_push_q) begin
      if (w_slot == 2'd0) r_d0 <= i_data;
      else                r_d1 <= i_data;
    end
  end
endmodule

// File: rtl/sram_pack_ctrl.sv
// Ring controller for a 4-word-write / 1-word-read single-port SRAM with a valid/ready
// burst input and a single-word valid/ready output.
module sram_pack_ctrl
  import sram_pack_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int DEPTH = 128,
  parameter int ADDRB = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data_0,
  input  logic [WIDTH-1:0] s_data_1,
  input  logic [WIDTH-1:0] s_data_2,
  input  logic [WIDTH-1:0] s_data_3,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [ADDRB-1:0] o_level,
  output logic             o_ena,
  output logic             o_wea,
  output logic             o_rea,
  output logic [ADDRB-1:0] o_addr_i,
  output logic [ADDRB-1:0] o_addr_o,
  output logic [WIDTH-1:0] o_dina_0,
  output logic [WIDTH-1:0] o_dina_1,
  output logic [WIDTH-1:0] o_dina_2,
  output logic [WIDTH-1:0] o_dina_3,
  input  logic [WIDTH-1:0] i_douta
);
  localparam logic [ADDRB:0]   CAP_LIM = (ADDRB+1)'(cap(DEPTH) - BURST);
  localparam logic [ADDRB-1:0] WR_LAST = ADDRB'(DEPTH - 2*BURST);
  localparam logic [ADDRB-1:0] RD_LAST = ADDRB'(DEPTH - BURST - 1);

  logic             r_run;
  logic [ADDRB-1:0] r_wr_ptr;
  logic [ADDRB-1:0] r_rd_ptr;
  logic [ADDRB:0]   r_wr_count;
  logic             r_inflight;
  logic             w_wr_acc;
  logic             w_rd_iss;
  logic             w_hand;
  logic             w_credit;
  logic [1:0]       w_skid_occ;

  always_comb begin
    s_ready  = r_run & ~i_clr & (r_wr_count <= CAP_LIM);
    w_wr_acc = s_valid & s_ready;
    w_hand   = m_valid & m_ready;
    // Issue only if the word will still have a skid slot when it returns next cycle.
    w_credit = (3'(w_skid_occ) + 3'(r_inflight)) < (3'(SKID_N) + 3'(w_hand));
    w_rd_iss = r_run & ~i_clr & (r_wr_count != '0) & w_credit;

    o_ena    = w_wr_acc | w_rd_iss;
    o_wea    = w_wr_acc;
    o_rea    = w_rd_iss;
    o_addr_i = w_wr_acc ? r_wr_ptr : '0;
    o_addr_o = w_rd_iss ? ADDRB'(r_rd_ptr + ADDRB'(1)) : '0;
    o_dina_0 = w_wr_acc ? s_data_0 : '0;
    o_dina_1 = w_wr_acc ? s_data_1 : '0;
    o_dina_2 = w_wr_acc ? s_data_2 : '0;
    o_dina_3 = w_wr_acc ? s_data_3 : '0;
    o_level  = ADDRB'(r_wr_count + (ADDRB+1)'(r_inflight) + (ADDRB+1)'(w_skid_occ));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_run      <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_wr_count <= '0;
      r_inflight <= 1'b0;
    end else if (i_clr) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_wr_count <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_run      <= 1'b1;
      r_inflight <= w_rd_iss;
      r_wr_count <= r_wr_count + (w_wr_acc ? (ADDRB+1)'(BURST) : '0) - (ADDRB+1)'(w_rd_iss);
      if (w_wr_acc) r_wr_ptr <= (r_wr_ptr == WR_LAST) ? '0 : ADDRB'(r_wr_ptr + ADDRB'(BURST));
      if (w_rd_iss) r_rd_ptr <= (r_rd_ptr == RD_LAST) ? '0 : ADDRB'(r_rd_ptr + ADDRB'(1));
    end
  end

  sram_rd_skid #(.WIDTH(WIDTH)) u_skid (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_flush (i_clr),
    .i_valid (r_inflight),
    .i_data  (i_douta),
    .i_ready (m_ready),
    .o_valid (m_valid),
    .o_data  (m_data),
    .o_occ   (w_skid_occ)
  );
endmodule

// File: tb/tb_sram_pack_ctrl.sv
// Scoreboard bench for sram_pack_ctrl with a behavioural SRAM model.
module tb_sram_pack_ctrl;
  localparam int WIDTH = 10;
  localparam int DEPTH = 128;
  localparam int ADDRB = 7;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clr = 1'b0;
  logic             s_valid = 1'b0;
  logic             m_ready = 1'b0;
  logic [WIDTH-1:0] sd0 = '0, sd1 = '0, sd2 = '0, sd3 = '0;
  logic             s_ready, m_valid, o_ena, o_wea, o_rea;
  logic [WIDTH-1:0] m_data, dina0, dina1, dina2, dina3;
  logic [WIDTH-1:0] douta = '0;
  logic [ADDRB-1:0] o_level, o_addr_i, o_addr_o;
  logic [WIDTH-1:0] mem [0:DEPTH-1];

  int checks = 0;
  int errors = 0;
  int q[$];
  int exp_wp = 0, exp_rp = 0, wraps = 0, exp_d = 0;
  int mr_mode = 0;
  logic             prev_stall = 1'b0;
  logic [WIDTH-1:0] prev_data = '0;

  sram_pack_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDRB(ADDRB)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_data_0(sd0), .s_data_1(sd1), .s_data_2(sd2), .s_data_3(sd3),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .o_level(o_level), .o_ena(o_ena), .o_wea(o_wea), .o_rea(o_rea),
    .o_addr_i(o_addr_i), .o_addr_o(o_addr_o),
    .o_dina_0(dina0), .o_dina_1(dina1), .o_dina_2(dina2), .o_dina_3(dina3),
    .i_douta(douta)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (o_ena && o_wea && int'(o_addr_i) + 3 < DEPTH) begin
      mem[int'(o_addr_i)]     <= dina0;
      mem[int'(o_addr_i) + 1] <= dina1;
      mem[int'(o_addr_i) + 2] <= dina2;
      mem[int'(o_addr_i) + 3] <= dina3;
    end
    if (o_ena && o_rea && o_addr_o != '0) douta <= mem[int'(o_addr_o) - 1];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: handshakes, address model, scoreboard and output stability.
  always @(negedge clk) begin
    if (!rst_n || clr) begin
      q.delete();
      exp_wp = 0;
      exp_rp = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 32'(m_valid), 32'd1);
        chk("hold_data", 32'(m_data), 32'(prev_data));
      end
      if (s_valid && s_ready) begin
        chk("addr_i", 32'(o_addr_i), 32'(exp_wp));
        q.push_back(int'(sd0)); q.push_back(int'(sd1));
        q.push_back(int'(sd2)); q.push_back(int'(sd3));
        if (exp_wp == DEPTH - 8) begin exp_wp = 0; wraps++; end
        else exp_wp += 4;
      end
      if (o_rea) begin
        chk("addr_o", 32'(o_addr_o), 32'(exp_rp + 1));
        exp_rp = (exp_rp == DEPTH - 5) ? 0 : exp_rp + 1;
      end
      if (m_valid && m_ready) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL extra_word actual=%0d expected=none", m_data);
        end else begin
          exp_d = q.pop_front();
          chk("data", 32'(m_data), 32'(exp_d));
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (mr_mode == 1) m_ready = 1'($urandom_range(0, 1));
    else if (mr_mode == 2) m_ready = ~m_ready;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic send(input int a, input int b, input int c, input int d);
    int n;
    sd0 = WIDTH'(a); sd1 = WIDTH'(b); sd2 = WIDTH'(c); sd3 = WIDTH'(d);
    s_valid = 1'b1;
    n = 0;
    #1;
    while (!s_ready && n < 600) begin cyc(); n++; end
    if (!s_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout actual=s_ready0 expected=s_ready1");
    end
    cyc();
    s_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((o_level != '0 || m_valid) && n < 3000) begin cyc(); n++; end
    chk("drain_level", 32'(o_level), 32'd0);
    chk("drain_queue", 32'(q.size()), 32'd0);
  endtask

  initial begin
    int w0;
    // Reset / idle
    repeat (5) cyc();
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_level", 32'(o_level), 32'd0);
    chk("rst_ena", 32'({o_ena, o_wea, o_rea}), 32'd0);
    chk("rst_addr", 32'({o_addr_i, o_addr_o}), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    rst_n = 1'b1;
    #1 chk("rel_s_ready0", 32'(s_ready), 32'd0);
    cyc();
    chk("rel_s_ready1", 32'(s_ready), 32'd1);
    chk("rel_m_valid", 32'(m_valid), 32'd0);
    chk("rel_level", 32'(o_level), 32'd0);

    // Single burst latency
    m_ready = 1'b1;
    sd0 = 10'd1; sd1 = 10'd2; sd2 = 10'd3; sd3 = 10'd4;
    s_valid = 1'b1;
    #1;
    chk("b1_wr_pins", 32'({o_ena, o_wea}), 32'd3);
    chk("b1_addr_i", 32'(o_addr_i), 32'd0);
    chk("b1_dina0", 32'(dina0), 32'd1);
    chk("b1_dina3", 32'(dina3), 32'd4);
    cyc();
    s_valid = 1'b0;
    #1;
    chk("b1_rea", 32'(o_rea), 32'd1);
    chk("b1_addr_o", 32'(o_addr_o), 32'd1);
    cyc();
    chk("b1_mv_t2", 32'(m_valid), 32'd1);
    chk("b1_md_t2", 32'(m_data), 32'd1);
    cyc(); chk("b1_md_t3", 32'(m_data), 32'd2);
    cyc(); chk("b1_md_t4", 32'(m_data), 32'd3);
    cyc(); chk("b1_md_t5", 32'(m_data), 32'd4);
    cyc(); chk("b1_mv_end", 32'(m_valid), 32'd0);
    drain();

    // Fill with downstream stalled
    m_ready = 1'b0;
    for (int i = 0; i < 31; i++) send(100 + 4*i, 101 + 4*i, 102 + 4*i, 103 + 4*i);
    repeat (3) cyc();
    chk("full_s_ready", 32'(s_ready), 32'd0);
    chk("full_level", 32'(o_level), 32'd124);
    sd0 = 10'd900; sd1 = 10'd901; sd2 = 10'd902; sd3 = 10'd903;
    s_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin cyc(); chk("full_hold", 32'(s_ready), 32'd0); end
    m_ready = 1'b1;
    send(900, 901, 902, 903);
    drain();

    // Wrap with random backpressure
    w0 = wraps;
    mr_mode = 1;
    for (int i = 0; i < 100; i++) send(4*i + 1, 4*i + 2, 4*i + 3, 4*i + 4);
    mr_mode = 0;
    m_ready = 1'b1;
    drain();
    chk("wrap_seen", 32'(wraps > w0), 32'd1);

    // Alternating backpressure
    mr_mode = 2;
    for (int i = 0; i < 8; i++) send(500 + 4*i, 501 + 4*i, 502 + 4*i, 503 + 4*i);
    mr_mode = 0;
    m_ready = 1'b1;
    drain();

    // Flush with data stored and a read in flight
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(600 + 4*i, 601 + 4*i, 602 + 4*i, 603 + 4*i);
    repeat (3) cyc();
    m_ready = 1'b1;
    cyc();
    m_ready = 1'b0;
    clr = 1'b1;
    #1;
    chk("clr_pre_level", 32'(o_level), 32'd11);
    chk("clr_s_ready", 32'(s_ready), 32'd0);
    cyc();
    clr = 1'b0;
    #1;
    chk("clr_level", 32'(o_level), 32'd0);
    chk("clr_m_valid", 32'(m_valid), 32'd0);
    m_ready = 1'b1;
    send(7, 8, 9, 10);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
